// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand bypass plus load-use stall sequencer with saturating stall counter
module fwd_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_use,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic [REG_AW-1:0]           ex_dst,
    input  logic                        ex_wb,
    input  logic                        ex_mem_read,
    input  logic [REG_AW-1:0]           mem_dst,
    input  logic                        mem_wb,
    input  logic [DATA_W-1:0]           mem_data,
    input  logic [REG_AW-1:0]           wb_dst,
    input  logic                        wb_wb,
    input  logic [DATA_W-1:0]           wb_data,
    output logic [NUM_SRC-1:0]          fwd_sel,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        stall,
    output logic                        bubble,
    output logic [CNT_W-1:0]            stall_count
);
    localparam int RW = $clog2(LOAD_LAT) + 1;

    logic [RW-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] id_hit;
    logic               haz;
    logic               in_stall;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] src;
        logic [REG_AW-1:0] isrc;
        logic              src_ok;
        logic              isrc_ok;
        logic              hit_mem;
        logic              hit_wb;
        assign src     = ex_src[k*REG_AW +: REG_AW];
        assign isrc    = id_src[k*REG_AW +: REG_AW];
        assign src_ok  = (ZERO_REG == 0) || (src != '0);
        assign isrc_ok = (ZERO_REG == 0) || (isrc != '0);
        assign hit_mem = src_ok && mem_wb && (mem_dst == src);
        assign hit_wb  = src_ok && wb_wb && (wb_dst == src);
        assign fwd_sel[k] = hit_mem | hit_wb;
        assign fwd_data[k*DATA_W +: DATA_W] = hit_mem ? mem_data : hit_wb ? wb_data : '0;
        assign id_hit[k] = isrc_ok && id_src_use[k] && (isrc == ex_dst);
    end

    assign haz      = ex_mem_read && ex_wb && (|id_hit);
    assign in_stall = (rem_q != '0);

    // state register: remaining stall cycles and stall statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    // next state: flush aborts, STALL counts down ignoring hazards, IDLE arms on a hazard
    always_comb begin
        rem_d = flush ? '0 : in_stall ? rem_q - 1'b1 : haz ? RW'(LOAD_LAT - 1) : rem_q;
        cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // outputs: stall the same cycle a hazard is seen, never while flushing or in reset
    always_comb begin
        stall       = rst_n && !flush && (in_stall || haz);
        bubble      = stall;
        stall_count = cnt_q;
    end
endmodule
